multicycle_ctrl: RTL

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/mips_pkg.sv | 68 ++++++
 rtl/mc_opclass.sv | 38 +++
 rtl/multicycle_ctrl.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared opcode/funct constants, state and instruction-class enums, and
// datapath select encodings for the multicycle MIPS-subset controller.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_SLT   = 6'h2a;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXE    = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_BR     = 3'd5,
    S_JMP    = 3'd6,
    S_TRAP   = 3'd7
  } state_t;

  typedef enum logic [3:0] {
    C_RALU, C_SLL, C_ORI, C_LUI, C_LW, C_LH, C_SW, C_SB,
    C_BEQ, C_J, C_JAL, C_JR, C_ILL
  } iclass_t;

  // Register destination: rt, rd, or $ra for JAL.
  localparam logic [1:0] REGDST_RT = 2'd0;
  localparam logic [1:0] REGDST_RD = 2'd1;
  localparam logic [1:0] REGDST_RA = 2'd2;

  localparam logic [1:0] PCSRC_PC4  = 2'd0;
  localparam logic [1:0] PCSRC_JUMP = 2'd1;
  localparam logic [1:0] PCSRC_REG  = 2'd2;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  localparam logic [1:0] EXT_ZERO = 2'd0;
  localparam logic [1:0] EXT_SIGN = 2'd1;
  localparam logic [1:0] EXT_LUI  = 2'd2;

  localparam logic [1:0] ALU_ADD   = 2'd0;
  localparam logic [1:0] ALU_SUB   = 2'd1;
  localparam logic [1:0] ALU_FUNCT = 2'd2;
  localparam logic [1:0] ALU_OR    = 2'd3;

  function automatic logic is_load(input iclass_t c);
    return c inside {C_LW, C_LH};
  endfunction

  function automatic logic is_store(input iclass_t c);
    return c inside {C_SW, C_SB};
  endfunction

endpackage

// File: rtl/mc_opclass.sv
// Combinational instruction classifier: maps opcode/funct to an instruction
// class and a legality flag.
module mc_opclass
  import mips_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output iclass_t    iclass,
  output logic       legal
);

  always_comb begin
    iclass = C_ILL;
    unique case (opcode)
      OP_RTYPE: begin
        unique case (funct)
          FN_ADDU, FN_SUBU, FN_SLT: iclass = C_RALU;
          FN_SLL:                   iclass = C_SLL;
          FN_JR:                    iclass = C_JR;
          default:                  iclass = C_ILL;
        endcase
      end
      OP_J:    iclass = C_J;
      OP_JAL:  iclass = C_JAL;
      OP_BEQ:  iclass = C_BEQ;
      OP_ORI:  iclass = C_ORI;
      OP_LUI:  iclass = C_LUI;
      OP_LW:   iclass = C_LW;
      OP_LH:   iclass = C_LH;
      OP_SW:   iclass = C_SW;
      OP_SB:   iclass = C_SB;
      default: iclass = C_ILL;
    endcase
  end

  assign legal = (iclass != C_ILL);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-subset control unit: FETCH/DECODE/EXE/MEM/WB/BR/JMP/TRAP
// sequencer with optional memory handshake and a retired-instruction counter.
module multicycle_ctrl
  import mips_pkg::*;
#(
  parameter int MEM_HANDSHAKE = 1,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             PCWr,
  output logic             IRWr,
  output logic             MemRd,
  output logic             MemWr,
  output logic             RegWr,
  output logic [1:0]       RegDst,
  output logic [1:0]       PCSrc,
  output logic [1:0]       MemtoReg,
  output logic [1:0]       EXTOp,
  output logic [1:0]       ALUop,
  output logic             ALUSrc,
  output logic             ALUSrc1,
  output logic             sb,
  output logic             lh,
  output logic             illegal,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instr_cnt
);

  state_t  cur, nxt;
  iclass_t iclass;
  logic    legal;
  logic    mem_done;
  logic    retire;

  mc_opclass u_opclass (
    .opcode (opcode),
    .funct  (funct),
    .iclass (iclass),
    .legal  (legal)
  );

  assign mem_done = (MEM_HANDSHAKE == 0) || mem_ready;
  assign retire   = (nxt == S_FETCH) && (cur inside {S_WB, S_BR, S_JMP, S_MEM});
  assign state    = cur;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur       <= S_FETCH;
      illegal   <= 1'b0;
      instr_cnt <= '0;
    end else begin
      cur <= nxt;
      if (nxt == S_TRAP) illegal <= 1'b1;
      if (retire) instr_cnt <= instr_cnt + 1'b1;
    end
  end

  always_comb begin
    // NOTE: every output gets a default before the case so no path through
    // the decode leaves a signal unassigned and infers a latch.
    nxt      = cur;
    PCWr     = 1'b0;
    IRWr     = 1'b0;
    MemRd    = 1'b0;
    MemWr    = 1'b0;
    RegWr    = 1'b0;
    RegDst   = REGDST_RT;
    PCSrc    = PCSRC_PC4;
    MemtoReg = WB_ALU;
    EXTOp    = EXT_ZERO;
    ALUop    = ALU_ADD;
    ALUSrc   = 1'b0;
    ALUSrc1  = 1'b0;
    sb       = 1'b0;
    lh       = 1'b0;
    // Reset holds every strobe low even though the state register already reads FETCH.
    if (!reset) begin
      unique case (cur)
        S_FETCH: begin
          MemRd = 1'b1;
          if (mem_done) begin
            IRWr  = 1'b1;
            PCWr  = 1'b1;
            PCSrc = PCSRC_PC4;
            nxt   = S_DECODE;
          end
        end
        S_DECODE: begin
          if (!legal) nxt = S_TRAP;
          else if (iclass == C_BEQ) nxt = S_BR;
          else if (iclass inside {C_J, C_JAL, C_JR}) nxt = S_JMP;
          else nxt = S_EXE;
        end
        S_EXE: begin
          unique case (iclass)
            C_RALU: ALUop = ALU_FUNCT;
            C_SLL: begin
              ALUop   = ALU_FUNCT;
              ALUSrc1 = 1'b1;
            end
            C_ORI: begin
              ALUSrc = 1'b1;
              EXTOp  = EXT_ZERO;
              ALUop  = ALU_OR;
            end
            C_LUI: begin
              ALUSrc = 1'b1;
              EXTOp  = EXT_LUI;
            end
            C_LW, C_LH, C_SW, C_SB: begin
              ALUSrc = 1'b1;
              EXTOp  = EXT_SIGN;
            end
            default: ;
          endcase
          nxt = (is_load(iclass) || is_store(iclass)) ? S_MEM : S_WB;
        end
        S_MEM: begin
          if (is_store(iclass)) begin
            MemWr = 1'b1;
            sb    = (iclass == C_SB);
          end else begin
            MemRd = 1'b1;
          end
          if (mem_done) nxt = is_load(iclass) ? S_WB : S_FETCH;
        end
        S_WB: begin
          RegWr = 1'b1;
          if (iclass inside {C_RALU, C_SLL}) RegDst = REGDST_RD;
          if (is_load(iclass)) MemtoReg = WB_MEM;
          lh  = (iclass == C_LH);
          nxt = S_FETCH;
        end
        S_BR: begin
          ALUop = ALU_SUB;
          PCWr  = zero;
          nxt   = S_FETCH;
        end
        S_JMP: begin
          PCWr  = 1'b1;
          PCSrc = (iclass == C_JR) ? PCSRC_REG : PCSRC_JUMP;
          if (iclass == C_JAL) begin
            RegWr    = 1'b1;
            RegDst   = REGDST_RA;
            MemtoReg = WB_PC4;
          end
          nxt = S_FETCH;
        end
        S_TRAP: nxt = S_TRAP;
      endcase
    end
  end

endmodule
